ap_generator: RTL and testbench

- Streams an arithmetic progression: first term, then each later term is the previous term plus or minus a common difference, for a programmed number of terms.
- Performs the inverse of the AP detection logic. It sources test and reference sequences that feed detector blocks in the same datapath.
- Emits one term per accepted valid/ready handshake.
- Arithmetic is modulo 2^WIDTH, the same as the existing 8-bit subtractor chain.

---
 rtl/ap_generator_if.sv | 33 +++
 rtl/ap_generator.sv | 150 +++++++++++++++
 tb/tb_ap_generator.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_generator_if.sv
// ap_generator_if: control/stream bundle for the arithmetic-progression generator.
// The master side (source of start/config, sink of terms) drives the request
// and term_ready; the slave side (the generator) drives status and the term stream.
// Stream handshake: a term transfers on a rising clk edge where term_valid and
// term_ready are both high; while term_valid is high and term_ready is low the
// term and term_last hold stable, and term_valid never drops without a transfer.
interface ap_generator_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
);
   logic             start;
   logic [WIDTH-1:0] first;
   logic [WIDTH-1:0] diff;
   logic             dec;
   logic [LEN_W-1:0] count;
   logic             busy;
   logic [WIDTH-1:0] term;
   logic             term_valid;
   logic             term_ready;
   logic             term_last;
   logic             done;
   logic             ovf;

   modport master (
      output start, first, diff, dec, count, term_ready,
      input  busy, term, term_valid, term_last, done, ovf
   );

   modport slave (
      input  start, first, diff, dec, count, term_ready,
      output busy, term, term_valid, term_last, done, ovf
   );
endinterface

// File: rtl/ap_generator.sv
// ap_generator: streams first, first+/-diff, ... for count terms, modulo 2^WIDTH.
// Optional macro AP_GEN_OVF_DET_EN: when defined, ovf is a sticky carry/borrow
// flag for emitted steps; otherwise ovf is tied to 0 and no carry logic exists.
// o_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for observation.
module ap_generator #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   ap_generator_if.slave bus,
   output logic [1:0]   o_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_term;
   logic [WIDTH-1:0] w_term_nxt;
   logic [WIDTH-1:0] r_diff;
   logic [WIDTH-1:0] w_diff_nxt;
   logic             r_dec;
   logic             w_dec_nxt;
   logic [LEN_W-1:0] r_remaining;
   logic [LEN_W-1:0] w_remaining_nxt;
   logic [WIDTH-1:0] w_step;
   logic             w_handshake;
   logic             w_last;

`ifdef AP_GEN_OVF_DET_EN
   logic             r_ovf;
   logic             w_ovf_nxt;
   logic [WIDTH:0]   w_step_ext;

   // Extended add/subtract: top bit is carry-out (add) or borrow-out (subtract).
   always_comb begin
      if (r_dec) begin
         w_step_ext = {1'b0, r_term} - {1'b0, r_diff};
      end else begin
         w_step_ext = {1'b0, r_term} + {1'b0, r_diff};
      end
      w_step = w_step_ext[WIDTH-1:0];
   end
`else
   // Plain modulo-2^WIDTH step; no carry/borrow is kept.
   always_comb begin
      if (r_dec) begin
         w_step = r_term - r_diff;
      end else begin
         w_step = r_term + r_diff;
      end
   end
`endif

   assign w_last      = (r_remaining == LEN_W'(1));
   assign w_handshake = (r_state == S_RUN) && bus.term_ready;

   // Next-state and next-register logic; every target defaulted to hold.
   always_comb begin
      w_state_nxt     = r_state;
      w_term_nxt      = r_term;
      w_diff_nxt      = r_diff;
      w_dec_nxt       = r_dec;
      w_remaining_nxt = r_remaining;
`ifdef AP_GEN_OVF_DET_EN
      w_ovf_nxt       = r_ovf;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
`ifdef AP_GEN_OVF_DET_EN
               w_ovf_nxt = 1'b0;
`endif
               if (bus.count != '0) begin
                  w_term_nxt      = bus.first;
                  w_diff_nxt      = bus.diff;
                  w_dec_nxt       = bus.dec;
                  w_remaining_nxt = bus.count;
                  w_state_nxt     = S_RUN;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (w_handshake) begin
               if (!w_last) begin
                  w_term_nxt      = w_step;
                  w_remaining_nxt = r_remaining - LEN_W'(1);
`ifdef AP_GEN_OVF_DET_EN
                  w_ovf_nxt       = r_ovf | w_step_ext[WIDTH];
`endif
               end else begin
                  // Final term taken: term keeps its last emitted value.
                  w_remaining_nxt = '0;
                  w_state_nxt     = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_term      <= '0;
         r_diff      <= '0;
         r_dec       <= 1'b0;
         r_remaining <= '0;
`ifdef AP_GEN_OVF_DET_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_term      <= w_term_nxt;
         r_diff      <= w_diff_nxt;
         r_dec       <= w_dec_nxt;
         r_remaining <= w_remaining_nxt;
`ifdef AP_GEN_OVF_DET_EN
         r_ovf       <= w_ovf_nxt;
`endif
      end
   end

   // Status outputs are decoded from state so reset clears them at once.
   assign bus.term       = r_term;
   assign bus.term_valid = (r_state == S_RUN);
   assign bus.term_last  = (r_state == S_RUN) && w_last;
   assign bus.done       = (r_state == S_DONE);
   assign bus.busy       = (r_state != S_IDLE);
`ifdef AP_GEN_OVF_DET_EN
   assign bus.ovf        = r_ovf;
`else
   assign bus.ovf        = 1'b0;
`endif
   assign o_state        = r_state;

endmodule

// File: tb/tb_ap_generator.sv
// tb_ap_generator: directed tests for ap_generator with hand-computed terms.
module tb_ap_generator;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

`ifdef AP_GEN_OVF_DET_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  ap_generator_if #(.WIDTH(8), .LEN_W(4)) bus ();

  ap_generator #(.WIDTH(8), .LEN_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: called at a negedge, returns at the next negedge with start low.
  // Config inputs are scrambled afterwards; latched values must not change.
  task automatic do_start(input logic [7:0] f, input logic [7:0] d,
                          input logic de, input logic [3:0] c);
    bus.start = 1'b1;
    bus.first = f;
    bus.diff  = d;
    bus.dec   = de;
    bus.count = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.first = 8'($urandom_range(0, 255));
    bus.diff  = 8'($urandom_range(0, 255));
    bus.dec   = 1'($urandom_range(0, 1));
    bus.count = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset;
    checks++; if (bus.term_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.term_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.term !== 8'd0) begin failures++; $display("FAIL rst_term got=%0d exp=0", bus.term); end
    checks++; if (bus.term_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", bus.term_last); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_increment;
    logic [7:0] e;
    do_start(8'd3, 8'd4, 1'b0, 4'd7);
    for (int i = 0; i < 7; i++) begin
      e = 8'(3 + 4 * i);
      checks++; if (bus.term_valid !== 1'b1) begin failures++; $display("FAIL inc_valid i=%0d got=%b exp=1", i, bus.term_valid); end
      checks++; if (bus.term !== e) begin failures++; $display("FAIL inc_term i=%0d got=%0d exp=%0d", i, bus.term, e); end
      checks++; if (bus.term_last !== (i == 6)) begin failures++; $display("FAIL inc_last i=%0d got=%b exp=%b", i, bus.term_last, (i == 6)); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL inc_done_early i=%0d got=%b exp=0", i, bus.done); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL inc_ovf i=%0d got=%b exp=0", i, bus.ovf); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL inc_done got=%b exp=1", bus.done); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL inc_busy_done got=%b exp=1", bus.busy); end
    checks++; if (bus.term_valid !== 1'b0) begin failures++; $display("FAIL inc_valid_done got=%b exp=0", bus.term_valid); end
    checks++; if (bus.term !== 8'd27) begin failures++; $display("FAIL inc_term_hold got=%0d exp=27", bus.term); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL inc_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL inc_busy_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_decrement;
    logic [7:0] e;
    do_start(8'd50, 8'd5, 1'b1, 4'd4);
    for (int i = 0; i < 4; i++) begin
      e = 8'(50 - 5 * i);
      checks++; if (bus.term !== e) begin failures++; $display("FAIL dec_term i=%0d got=%0d exp=%0d", i, bus.term, e); end
      checks++; if (bus.term_last !== (i == 3)) begin failures++; $display("FAIL dec_last i=%0d got=%b exp=%b", i, bus.term_last, (i == 3)); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL dec_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k;
    logic [7:0] e;
    logic rdy;
    k = 0;
    do_start(8'd3, 8'd4, 1'b0, 4'd7);
    for (int c = 0; c < 10; c++) begin
      rdy = !(c >= 1 && c <= 3);
      bus.term_ready = rdy;
      e = 8'(3 + 4 * k);
      checks++; if (bus.term_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.term_valid); end
      checks++; if (bus.term !== e) begin failures++; $display("FAIL bp_term c=%0d got=%0d exp=%0d", c, bus.term, e); end
      checks++; if (bus.term_last !== (k == 6)) begin failures++; $display("FAIL bp_last c=%0d got=%b exp=%b", c, bus.term_last, (k == 6)); end
      @(negedge clk);
      if (rdy) k++;
    end
    bus.term_ready = 1'b1;
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", bus.done); end
    checks++; if (bus.term !== 8'd27) begin failures++; $display("FAIL bp_final got=%0d exp=27", bus.term); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [7:0] exp_t[3];
    exp_t[0] = 8'd250; exp_t[1] = 8'd253; exp_t[2] = 8'd0;
    do_start(8'd250, 8'd3, 1'b0, 4'd3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.term !== exp_t[i]) begin failures++; $display("FAIL wrap_term i=%0d got=%0d exp=%0d", i, bus.term, exp_t[i]); end
      checks++; if (bus.ovf !== (OVF_EN && i == 2)) begin failures++; $display("FAIL wrap_ovf i=%0d got=%b exp=%b", i, bus.ovf, (OVF_EN && i == 2)); end
      @(negedge clk);
    end
    checks++; if (bus.ovf !== OVF_EN) begin failures++; $display("FAIL wrap_ovf_done got=%b exp=%b", bus.ovf, OVF_EN); end
    @(negedge clk);
    checks++; if (bus.ovf !== OVF_EN) begin failures++; $display("FAIL wrap_ovf_idle got=%b exp=%b", bus.ovf, OVF_EN); end
    do_start(8'd1, 8'd1, 1'b0, 4'd2);
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL wrap_ovf_clear got=%b exp=0", bus.ovf); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.term !== 8'(1 + i)) begin failures++; $display("FAIL wrap_next_term i=%0d got=%0d exp=%0d", i, bus.term, 1 + i); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL wrap_next_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_zero_count;
    do_start(8'd9, 8'd9, 1'b0, 4'd0);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", bus.done); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.term_valid !== 1'b0) begin failures++; $display("FAIL zero_valid got=%b exp=0", bus.term_valid); end
    checks++; if (bus.term !== 8'd2) begin failures++; $display("FAIL zero_term_hold got=%0d exp=2", bus.term); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.term_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL zero_after i=%0d got done=%b valid=%b busy=%b exp all 0", i, bus.done, bus.term_valid, bus.busy);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [7:0] e;
    int n_done;
    n_done = 0;
    do_start(8'd3, 8'd4, 1'b0, 4'd7);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        bus.start = 1'b1; bus.first = 8'd99; bus.count = 4'd1; bus.dec = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
      e = 8'(3 + 4 * i);
      checks++; if (bus.term !== e) begin failures++; $display("FAIL busy_term i=%0d got=%0d exp=%0d", i, bus.term, e); end
      checks++; if (bus.term_last !== (i == 6)) begin failures++; $display("FAIL busy_last i=%0d got=%b exp=%b", i, bus.term_last, (i == 6)); end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", n_done); end
    checks++; if (bus.term_valid !== 1'b0) begin failures++; $display("FAIL busy_no_restart got=%b exp=0", bus.term_valid); end
  endtask

  task automatic test_max_count;
    logic [7:0] e;
    do_start(8'd0, 8'd17, 1'b0, 4'd15);
    for (int i = 0; i < 15; i++) begin
      e = 8'(17 * i);
      checks++; if (bus.term !== e || bus.term_valid !== 1'b1) begin failures++; $display("FAIL max_term i=%0d got=%0d valid=%b exp=%0d", i, bus.term, bus.term_valid, e); end
      checks++; if (bus.term_last !== (i == 14)) begin failures++; $display("FAIL max_last i=%0d got=%b exp=%b", i, bus.term_last, (i == 14)); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL max_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_start(8'd10, 8'd1, 1'b0, 4'd2);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
    @(negedge clk);
    do_start(8'd100, 8'd10, 1'b1, 4'd2);
    checks++; if (bus.term !== 8'd100 || bus.term_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0d valid=%b exp=100", bus.term, bus.term_valid); end
    @(negedge clk);
    checks++; if (bus.term !== 8'd90 || bus.term_last !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d last=%b exp=90 last=1", bus.term, bus.term_last); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    do_start(8'd3, 8'd4, 1'b0, 4'd7);
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++; if (bus.term !== 8'd15) begin failures++; $display("FAIL rmid_pre got=%0d exp=15", bus.term); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.term_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL rmid_async got valid=%b busy=%b done=%b exp all 0", bus.term_valid, bus.busy, bus.done);
    end
    checks++; if (bus.term !== 8'd0 || bus.ovf !== 1'b0 || bus.term_last !== 1'b0) begin
      failures++; $display("FAIL rmid_async_term got term=%0d ovf=%b last=%b exp 0", bus.term, bus.ovf, bus.term_last);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done || bus.busy) n_done++;
      @(negedge clk);
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", n_done); end
    do_start(8'd0, 8'd2, 1'b0, 4'd2);
    checks++; if (bus.term !== 8'd0 || bus.term_valid !== 1'b1) begin failures++; $display("FAIL rmid_t0 got=%0d valid=%b exp=0", bus.term, bus.term_valid); end
    @(negedge clk);
    checks++; if (bus.term !== 8'd2 || bus.term_last !== 1'b1) begin failures++; $display("FAIL rmid_t1 got=%0d last=%b exp=2", bus.term, bus.term_last); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.first = '0;
    bus.diff = '0;
    bus.dec = 1'b0;
    bus.count = '0;
    bus.term_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    test_increment;
    test_decrement;
    test_backpressure;
    test_wrap;
    test_zero_count;
    test_start_while_busy;
    test_max_count;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
